io_ctrl: RTL and testbench
==========================

# io_ctrl

Core-side controller behind the chip pad ring. It decodes the narrow host IO opcode/data bus and uses it to load and read back on-chip memory words over a wide request/grant port. It also sequences the start, completion and reset of DAG execution for the core. It sits between the IO pad wrapper's core-side signals and the core's memory/execution interfaces.

## Interface
- IN_W, 32: host input data width (in_data)
- OUT_W, 32: host output data width (out_data)
- OP_W, 3: opcode width
- ADDR_W, 16: memory word address width
- WORD_W, 128: memory word width; must be a multiple of IN_W and OUT_W. BEATS_IN = WORD_W/IN_W, BEATS_OUT = WORD_W/OUT_W.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- io_opcode  in  OP_W  host opcode
- in_data  in  IN_W  host data
- enable_execution_io  in  1  host start request (level)
- reset_execution_io  in  1  host execution reset (level)
- done_execution_io  out  1  ready/done indicator to host
- out_data  out  OUT_W  read-back beat to host
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WORD_W  write word
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WORD_W  read word
- exec_start  out  1  one-cycle start pulse to core
- exec_reset  out  1  core execution reset (level)
- exec_done  in  1  core completion pulse

## Operation
- All host inputs are registered once before use. "Edge t" is the edge at which the registered value is acted on. All outputs are registered.
- Opcodes:
  - 0 NOP
  - 1 SET_ADDR: addr <= in_data[ADDR_W-1:0], zero-extended; wcnt <= 0, which discards any partial write word.
  - 2 WR_BEAT: wbuf[wcnt*IN_W +: IN_W] <= in_data; wcnt++. When wcnt was BEATS_IN-1, go to WR_REQ.
  - 3 RD_WORD: go to RD_REQ.
  - 4 RD_BEAT: out_data <= rbuf[rcnt*OUT_W +: OUT_W]; rcnt wraps modulo BEATS_OUT.
  - 5–7 are reserved and act as NOP.
- States: IDLE, WR_REQ, RD_REQ, RD_WAIT, EXEC. Opcodes are decoded only in IDLE; in every other state they are ignored.
- WR_REQ: mem_req = 1, mem_we = 1, mem_addr = addr, mem_wdata = wbuf, all held stable until mem_gnt. On gnt: addr++ (wraps modulo 2^ADDR_W), wcnt <= 0, go to IDLE.
- RD_REQ: mem_req = 1, mem_we = 0 until mem_gnt, then go to RD_WAIT.
- RD_WAIT: mem_rvalid is sampled only in this state, so it is ignored in the gnt cycle. On rvalid: rbuf <= mem_rdata, rcnt <= 0, addr++, go to IDLE.
- In IDLE, a rising edge of enable_execution_io (registered 0→1) pulses exec_start for one cycle and moves to EXEC. While enable stays high, no further start is issued.
- EXEC: exec_done moves to IDLE and sets done_flag. Memory opcodes are ignored while in EXEC.
- done_execution_io:
  - in EXEC: 0
  - in IDLE: 1
  - in WR_REQ, RD_REQ, RD_WAIT: 0
  - The host polls it as ready/done; done_flag is for internal observation only.
- reset_execution_io (registered) has the highest priority in every state:
  - exec_reset = 1 while it is high
  - FSM goes to IDLE; mem_req drops next cycle
  - wcnt and rcnt are cleared
  - addr, wbuf, rbuf and out_data are kept
  - an enable edge in the same cycle is ignored
  - a pending memory access is abandoned, and the memory must tolerate a withdrawn request
- If exec_done and reset_execution_io arrive in the same cycle, reset wins and the net result is still IDLE.

## Timing
- Reset values:
  - done_execution_io = 1
  - all other outputs 0
  - addr, wcnt, rcnt, wbuf, rbuf = 0
  - state IDLE
- Host input to action: 1 cycle pad-register latency.
- Final WR_BEAT at edge t: mem_req = 1 and done_execution_io = 0 after edge t. With gnt present at edge t+1, done_execution_io = 1 after edge t+1.
- RD_WORD at edge t: mem_req after edge t. With gnt at edge g and rvalid at edge r > g, rbuf is loaded and done_execution_io = 1 after edge r.
- RD_BEAT at edge t: out_data valid after edge t; the host samples it after seeing done_execution_io high.
- Enable edge acted on at edge t: exec_start is high for exactly the cycle after edge t.
- exec_done at edge d: done_execution_io = 1 after edge d.
- rst is asynchronous: it forces reset values immediately, independent of clk.

## Test plan
- Write then read: SET_ADDR 0x0010, then 4× WR_BEAT 0x11111111, 0x22222222, 0x33333333, 0x44444444, with gnt delayed 3 cycles. Expect mem_wdata = 0x44444444_33333333_22222222_11111111 at addr 0x0010 and addr → 0x0011. Then SET_ADDR 0x0010, RD_WORD returning the same data after 2 cycles, then 4× RD_BEAT. Expect out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444; a fifth RD_BEAT returns 0x11111111.
- Address wrap: SET_ADDR 0xFFFF, complete one write. Expect addr = 0x0000.
- Partial-word discard: 2× WR_BEAT, then SET_ADDR 0x0005, then 4× WR_BEAT. Expect exactly one write, at 0x0005, containing only the last 4 beats.
- Execution: hold enable high for 10 cycles. Expect one exec_start pulse and done_execution_io = 0 throughout. WR_BEAT issued during EXEC causes no mem_req. exec_done after 50 cycles gives done_execution_io = 1.
- Abort: assert reset_execution_io during RD_WAIT, and separately during EXEC coincident with exec_done. Expect exec_reset high, mem_req low next cycle, IDLE with done_execution_io = 1, and addr unchanged.
- Async reset mid-WR_REQ: assert rst. Expect mem_req = 0 and done_execution_io = 1 without a clk edge.

Source files
------------

// File: rtl/io_ctrl.sv
// Core-side host IO controller: decodes the host opcode/data bus into memory word
// writes/reads over a request/grant port and sequences DAG execution start/reset.
module io_ctrl #(
   parameter int unsigned IN_W   = 32,
   parameter int unsigned OUT_W  = 32,
   parameter int unsigned OP_W   = 3,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned WORD_W = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [OP_W-1:0]   io_opcode,
   input  logic [IN_W-1:0]   in_data,
   input  logic              enable_execution_io,
   input  logic              reset_execution_io,
   output logic              done_execution_io,
   output logic [OUT_W-1:0]  out_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              exec_start,
   output logic              exec_reset,
   input  logic              exec_done
);

   localparam int unsigned BEATS_IN  = WORD_W / IN_W;
   localparam int unsigned BEATS_OUT = WORD_W / OUT_W;
   localparam int unsigned WCNT_W    = (BEATS_IN  > 1) ? $clog2(BEATS_IN)  : 1;
   localparam int unsigned RCNT_W    = (BEATS_OUT > 1) ? $clog2(BEATS_OUT) : 1;

   localparam logic [OP_W-1:0] OP_NOP      = OP_W'(0);
   localparam logic [OP_W-1:0] OP_SET_ADDR = OP_W'(1);
   localparam logic [OP_W-1:0] OP_WR_BEAT  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_RD_WORD  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_RD_BEAT  = OP_W'(4);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_REQ  = 3'd1,
      S_RD_REQ  = 3'd2,
      S_RD_WAIT = 3'd3,
      S_EXEC    = 3'd4
   } state_t;

   state_t state_q, state_d;

   // Pad-side input registers
   logic [OP_W-1:0] op_q;
   logic [IN_W-1:0] din_q;
   logic            en_q, en_prev_q, xrst_q;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic [WORD_W-1:0] wbuf_q, wbuf_d;
   logic [WORD_W-1:0] rbuf_q, rbuf_d;
   logic              done_flag_q, done_flag_d;

   logic [OUT_W-1:0] out_data_d;
   logic             mem_req_d, mem_we_d, exec_start_d, exec_reset_d, done_d;
   logic             en_rise_c;

   assign en_rise_c = en_q & ~en_prev_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wbuf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wcnt_d       = wcnt_q;
      rcnt_d       = rcnt_q;
      wbuf_d       = wbuf_q;
      rbuf_d       = rbuf_q;
      done_flag_d  = done_flag_q;
      out_data_d   = out_data;
      exec_start_d = 1'b0;

      if (xrst_q) begin
         // Execution reset abandons any access; addr and buffers survive
         state_d = S_IDLE;
         wcnt_d  = '0;
         rcnt_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en_rise_c) begin
                  state_d      = S_EXEC;
                  exec_start_d = 1'b1;
                  done_flag_d  = 1'b0;
               end else begin
                  case (op_q)
                     OP_NOP: ;
                     OP_SET_ADDR: begin
                        addr_d = din_q[ADDR_W-1:0];
                        wcnt_d = '0;
                     end
                     OP_WR_BEAT: begin
                        for (int unsigned i = 0; i < BEATS_IN; i++) begin
                           if (wcnt_q == WCNT_W'(i)) wbuf_d[i*IN_W +: IN_W] = din_q;
                        end
                        if (wcnt_q == WCNT_W'(BEATS_IN - 1)) begin
                           wcnt_d  = '0;
                           state_d = S_WR_REQ;
                        end else begin
                           wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                     end
                     OP_RD_WORD: state_d = S_RD_REQ;
                     OP_RD_BEAT: begin
                        for (int unsigned i = 0; i < BEATS_OUT; i++) begin
                           if (rcnt_q == RCNT_W'(i)) out_data_d = rbuf_q[i*OUT_W +: OUT_W];
                        end
                        if (rcnt_q == RCNT_W'(BEATS_OUT - 1)) rcnt_d = '0;
                        else                                  rcnt_d = rcnt_q + RCNT_W'(1);
                     end
                     default: ;
                  endcase
               end
            end
            S_WR_REQ: begin
               if (mem_gnt) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  wcnt_d  = '0;
                  state_d = S_IDLE;
               end
            end
            S_RD_REQ: begin
               if (mem_gnt) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (mem_rvalid) begin
                  rbuf_d  = mem_rdata;
                  rcnt_d  = '0;
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = S_IDLE;
               end
            end
            S_EXEC: begin
               if (exec_done) begin
                  done_flag_d = 1'b1;
                  state_d     = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Outputs follow the state being entered so they are valid right after the edge
      mem_req_d    = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
      mem_we_d     = (state_d == S_WR_REQ);
      done_d       = (state_d == S_IDLE);
      exec_reset_d = xrst_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q              <= '0;
         din_q             <= '0;
         en_q              <= 1'b0;
         en_prev_q         <= 1'b0;
         xrst_q            <= 1'b0;
         addr_q            <= '0;
         wcnt_q            <= '0;
         rcnt_q            <= '0;
         wbuf_q            <= '0;
         rbuf_q            <= '0;
         done_flag_q       <= 1'b0;
         out_data          <= '0;
         mem_req           <= 1'b0;
         mem_we            <= 1'b0;
         exec_start        <= 1'b0;
         exec_reset        <= 1'b0;
         done_execution_io <= 1'b1;
      end else begin
         op_q              <= io_opcode;
         din_q             <= in_data;
         en_q              <= enable_execution_io;
         en_prev_q         <= en_q;
         xrst_q            <= reset_execution_io;
         addr_q            <= addr_d;
         wcnt_q            <= wcnt_d;
         rcnt_q            <= rcnt_d;
         wbuf_q            <= wbuf_d;
         rbuf_q            <= rbuf_d;
         done_flag_q       <= done_flag_d;
         out_data          <= out_data_d;
         mem_req           <= mem_req_d;
         mem_we            <= mem_we_d;
         exec_start        <= exec_start_d;
         exec_reset        <= exec_reset_d;
         done_execution_io <= done_d;
      end
   end

endmodule

// File: tb/tb_io_ctrl.sv
// Directed vector bench for io_ctrl: opcode table plus hand-written memory,
// execution, abort and async-reset sequences.
module tb_io_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic [2:0]   io_opcode;
   logic [31:0]  in_data;
   logic         enable_execution_io, reset_execution_io;
   logic         done_execution_io;
   logic [31:0]  out_data;
   logic         mem_req, mem_we;
   logic [15:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_gnt, mem_rvalid;
   logic [127:0] mem_rdata;
   logic         exec_start, exec_reset, exec_done;

   int n_cmp = 0;
   int n_err = 0;

   io_ctrl dut (
      .clk(clk), .rst(rst), .io_opcode(io_opcode), .in_data(in_data),
      .enable_execution_io(enable_execution_io), .reset_execution_io(reset_execution_io),
      .done_execution_io(done_execution_io), .out_data(out_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .exec_start(exec_start), .exec_reset(exec_reset), .exec_done(exec_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] data;
      logic        exp_req;
      logic [15:0] exp_addr;
      logic [31:0] exp_out;
      logic        exp_done;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one opcode for a cycle; on return the action edge has just passed
   task automatic host_op(input logic [2:0] op, input logic [31:0] d);
      io_opcode = op;
      in_data   = d;
      tick();
      io_opcode = 3'd0;
      in_data   = '0;
      tick();
   endtask

   task automatic apply_vec(input int i);
      host_op(vecs[i].op, vecs[i].data);
      chk($sformatf("v%0d req", i),  128'(mem_req),           128'(vecs[i].exp_req));
      chk($sformatf("v%0d addr", i), 128'(mem_addr),          128'(vecs[i].exp_addr));
      chk($sformatf("v%0d out", i),  128'(out_data),          128'(vecs[i].exp_out));
      chk($sformatf("v%0d done", i), 128'(done_execution_io), 128'(vecs[i].exp_done));
   endtask

   initial begin
      logic [127:0] word;
      int starts;
      int bad;
      word = 128'h44444444_33333333_22222222_11111111;

      vecs[0]  = '{3'd1, 32'h0000_0010, 1'b0, 16'h0010, 32'h0,        1'b1};
      vecs[1]  = '{3'd2, 32'h1111_1111, 1'b0, 16'h0010, 32'h0,        1'b1};
      vecs[2]  = '{3'd2, 32'h2222_2222, 1'b0, 16'h0010, 32'h0,        1'b1};
      vecs[3]  = '{3'd2, 32'h3333_3333, 1'b0, 16'h0010, 32'h0,        1'b1};
      vecs[4]  = '{3'd2, 32'h4444_4444, 1'b1, 16'h0010, 32'h0,        1'b0};
      vecs[5]  = '{3'd1, 32'hABCD_0010, 1'b0, 16'h0010, 32'h0,        1'b1};
      vecs[6]  = '{3'd3, 32'h0,         1'b1, 16'h0010, 32'h0,        1'b0};
      vecs[7]  = '{3'd4, 32'h0,         1'b0, 16'h0011, 32'h11111111, 1'b1};
      vecs[8]  = '{3'd4, 32'h0,         1'b0, 16'h0011, 32'h22222222, 1'b1};
      vecs[9]  = '{3'd5, 32'h0000_0099, 1'b0, 16'h0011, 32'h22222222, 1'b1};
      vecs[10] = '{3'd4, 32'h0,         1'b0, 16'h0011, 32'h33333333, 1'b1};
      vecs[11] = '{3'd7, 32'h0000_0077, 1'b0, 16'h0011, 32'h33333333, 1'b1};
      vecs[12] = '{3'd4, 32'h0,         1'b0, 16'h0011, 32'h44444444, 1'b1};
      vecs[13] = '{3'd4, 32'h0,         1'b0, 16'h0011, 32'h11111111, 1'b1};
      vecs[14] = '{3'd0, 32'h0,         1'b0, 16'h0011, 32'h11111111, 1'b1};

      rst = 1'b1;
      io_opcode = '0; in_data = '0;
      enable_execution_io = 1'b0; reset_execution_io = 1'b0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; exec_done = 1'b0;

      // Reset values
      #2;
      chk("rst done",  128'(done_execution_io), 128'(1));
      chk("rst req",   128'(mem_req),    128'(0));
      chk("rst we",    128'(mem_we),     128'(0));
      chk("rst addr",  128'(mem_addr),   128'(0));
      chk("rst wdata", mem_wdata,        128'(0));
      chk("rst out",   128'(out_data),   128'(0));
      chk("rst start", 128'(exec_start), 128'(0));
      chk("rst xrst",  128'(exec_reset), 128'(0));
      #10 rst = 1'b0;
      tick();

      // Write a word, grant held off three cycles
      for (int i = 0; i <= 4; i++) apply_vec(i);
      chk("wr we", 128'(mem_we), 128'(1));
      chk("wr wdata", mem_wdata, word);
      tick();
      tick();
      chk("wr hold req", 128'(mem_req), 128'(1));
      chk("wr hold wdata", mem_wdata, word);
      chk("wr hold addr", 128'(mem_addr), 128'h10);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("wr gnt req", 128'(mem_req), 128'(0));
      chk("wr gnt done", 128'(done_execution_io), 128'(1));
      chk("wr gnt addr", 128'(mem_addr), 128'h11);

      // Read it back; rvalid during the grant cycle must be ignored
      for (int i = 5; i <= 6; i++) apply_vec(i);
      chk("rd we", 128'(mem_we), 128'(0));
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = {4{32'hDEADBEEF}};
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk("rd wait req", 128'(mem_req), 128'(0));
      chk("rd wait done", 128'(done_execution_io), 128'(0));
      tick();
      chk("rd wait2 done", 128'(done_execution_io), 128'(0));
      mem_rvalid = 1'b1; mem_rdata = word;
      tick();
      mem_rvalid = 1'b0; mem_rdata = '0;
      chk("rd done", 128'(done_execution_io), 128'(1));
      chk("rd addr", 128'(mem_addr), 128'h11);
      for (int i = 7; i <= 14; i++) apply_vec(i);

      // Address wrap with immediate grant
      host_op(3'd1, 32'h0000_FFFF);
      for (int b = 0; b < 4; b++) host_op(3'd2, 32'hC0DE_0000 + 32'(b));
      chk("wrap req", 128'(mem_req), 128'(1));
      chk("wrap addr pre", 128'(mem_addr), 128'hFFFF);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("wrap done", 128'(done_execution_io), 128'(1));
      chk("wrap addr", 128'(mem_addr), 128'h0000);

      // Partial word discarded by SET_ADDR
      host_op(3'd2, 32'hAAAA_AAAA);
      host_op(3'd2, 32'hBBBB_BBBB);
      host_op(3'd1, 32'h0000_0005);
      for (int b = 0; b < 3; b++) begin
         host_op(3'd2, 32'h5 + 32'(b));
         chk($sformatf("part req b%0d", b), 128'(mem_req), 128'(0));
      end
      host_op(3'd2, 32'h8);
      chk("part req", 128'(mem_req), 128'(1));
      chk("part addr", 128'(mem_addr), 128'h5);
      chk("part wdata", mem_wdata, 128'h00000008_00000007_00000006_00000005);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("part addr post", 128'(mem_addr), 128'h6);

      // Execution: enable held for several cycles gives one start
      enable_execution_io = 1'b1;
      starts = 0; bad = 0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (exec_start) starts++;
         if (c >= 2 && done_execution_io !== 1'b0) bad++;
         if (c == 10) enable_execution_io = 1'b0;
      end
      chk("exec starts", 128'(starts), 128'(1));
      chk("exec done low", 128'(bad), 128'(0));
      for (int b = 0; b < 4; b++) host_op(3'd2, 32'hF00D_0000);
      chk("exec wr req", 128'(mem_req), 128'(0));
      chk("exec wr done", 128'(done_execution_io), 128'(0));
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (done_execution_io !== 1'b0 || mem_req !== 1'b0) bad++;
      end
      chk("exec wait", 128'(bad), 128'(0));
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      chk("exec done", 128'(done_execution_io), 128'(1));

      // Abort during RD_WAIT
      host_op(3'd1, 32'h0000_0020);
      host_op(3'd3, 32'h0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("ab rw done0", 128'(done_execution_io), 128'(0));
      reset_execution_io = 1'b1;
      tick();
      chk("ab rw xrst lat", 128'(exec_reset), 128'(0));
      tick();
      chk("ab rw xrst", 128'(exec_reset), 128'(1));
      chk("ab rw req", 128'(mem_req), 128'(0));
      chk("ab rw done", 128'(done_execution_io), 128'(1));
      chk("ab rw addr", 128'(mem_addr), 128'h20);
      reset_execution_io = 1'b0;
      tick();
      tick();
      chk("ab rw xrst off", 128'(exec_reset), 128'(0));
      mem_rvalid = 1'b1; mem_rdata = {4{32'h0BAD0BAD}};
      tick();
      mem_rvalid = 1'b0; mem_rdata = '0;
      chk("ab late rvalid addr", 128'(mem_addr), 128'h20);
      host_op(3'd4, 32'h0);
      chk("ab rbuf kept", 128'(out_data), 128'h11111111);

      // Abort during RD_REQ withdraws the request
      host_op(3'd3, 32'h0);
      chk("ab rq req", 128'(mem_req), 128'(1));
      reset_execution_io = 1'b1;
      tick();
      chk("ab rq req lat", 128'(mem_req), 128'(1));
      tick();
      chk("ab rq req", 128'(mem_req), 128'(0));
      chk("ab rq done", 128'(done_execution_io), 128'(1));
      reset_execution_io = 1'b0;
      tick();
      tick();

      // Abort during EXEC coincident with exec_done
      enable_execution_io = 1'b1;
      tick();
      tick();
      chk("ab ex start", 128'(exec_start), 128'(1));
      chk("ab ex done0", 128'(done_execution_io), 128'(0));
      reset_execution_io = 1'b1;
      tick();
      exec_done = 1'b1;
      tick();
      exec_done = 1'b0;
      chk("ab ex xrst", 128'(exec_reset), 128'(1));
      chk("ab ex done", 128'(done_execution_io), 128'(1));
      chk("ab ex addr", 128'(mem_addr), 128'h20);
      reset_execution_io = 1'b0;
      tick();
      tick();
      chk("ab ex no restart", 128'(exec_start), 128'(0));
      chk("ab ex idle", 128'(done_execution_io), 128'(1));
      enable_execution_io = 1'b0;
      tick();

      // Enable edge coincident with execution reset is dropped
      enable_execution_io = 1'b1;
      reset_execution_io  = 1'b1;
      tick();
      tick();
      chk("en+rst start", 128'(exec_start), 128'(0));
      reset_execution_io = 1'b0;
      starts = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (exec_start) starts++;
      end
      chk("en+rst later start", 128'(starts), 128'(0));
      chk("en+rst done", 128'(done_execution_io), 128'(1));
      enable_execution_io = 1'b0;
      tick();

      // Asynchronous reset while a write request is pending
      for (int b = 0; b < 4; b++) host_op(3'd2, 32'h7777_0000 + 32'(b));
      chk("async pre req", 128'(mem_req), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("async req", 128'(mem_req), 128'(0));
      chk("async done", 128'(done_execution_io), 128'(1));
      chk("async addr", 128'(mem_addr), 128'(0));
      chk("async wdata", mem_wdata, 128'(0));
      #3 rst = 1'b0;
      tick();
      chk("async post done", 128'(done_execution_io), 128'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
